led_channel_driver: RTL

//   Parametrised N-channel LED driver; successor to the fixed single-LED heartbeat counter in the board top level.
//   - Each channel runs independently in one of four modes: OFF, ON, BLINK, PULSE.
//   - Each channel has its own half-period. Channels are reconfigured at runtime over a valid/ready config port.
//   - PULSE mode gives a retriggerable one-shot (activity LED) driven by trig[i].
//   - Sits in the board top level beside the SoC; cfg_* is driven by SoC GPIO or a bridge.

---
 rtl/led_channel_driver.sv | 118 +++++++++++
 1 files changed

// File: rtl/led_channel_driver.sv
// N-channel LED driver: each channel runs OFF / ON / BLINK / PULSE with its own
// half-period, reconfigured at runtime through a valid/ready config port.
module led_channel_driver #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 32,
  parameter int DEF_HALF = 50_000_000,
  // Derived from N_CH by default; widening it makes out-of-range indices expressible.
  parameter int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_chan,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic [N_CH-1:0]  trig,
  output logic [N_CH-1:0]  led
);

  // Handshake: a request transfers on a clock edge where cfg_valid and cfg_ready
  // are both 1; cfg_ready is registered and stays 1 from the first edge after reset.
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PULSE = 2'd3
  } mode_t;

  mode_t            mode_q  [N_CH];
  mode_t            mode_d  [N_CH];
  logic [CNT_W-1:0] half_q  [N_CH];
  logic [CNT_W-1:0] half_d  [N_CH];
  logic [CNT_W-1:0] count_q [N_CH];
  logic [CNT_W-1:0] count_d [N_CH];
  logic [N_CH-1:0]  led_q, led_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             cfg_fire;
  logic [CNT_W-1:0] cfg_half_clamped;

  always_comb begin
    cfg_fire         = cfg_valid & cfg_ready_q;
    cfg_half_clamped = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
    cfg_ready_d      = 1'b1;
    led_d            = led_q;
    for (int i = 0; i < N_CH; i++) begin
      mode_d[i]  = mode_q[i];
      half_d[i]  = half_q[i];
      count_d[i] = count_q[i];
      unique case (mode_q[i])
        MODE_OFF: begin
          led_d[i]   = 1'b0;
          count_d[i] = '0;
        end
        MODE_ON: begin
          led_d[i]   = 1'b1;
          count_d[i] = '0;
        end
        MODE_BLINK: begin
          if (count_q[i] == half_q[i] - CNT_W'(1)) begin
            led_d[i]   = ~led_q[i];
            count_d[i] = '0;
          end else begin
            count_d[i] = count_q[i] + CNT_W'(1);
          end
        end
        MODE_PULSE: begin
          // A trigger restarts the window even when the LED is already lit.
          if (trig[i]) begin
            led_d[i]   = 1'b1;
            count_d[i] = '0;
          end else if (led_q[i]) begin
            if (count_q[i] == half_q[i] - CNT_W'(1)) begin
              led_d[i]   = 1'b0;
              count_d[i] = '0;
            end else begin
              count_d[i] = count_q[i] + CNT_W'(1);
            end
          end else begin
            count_d[i] = '0;
          end
        end
        default: ;
      endcase
      // An accepted request overrides this channel's own toggle or trigger.
      if (cfg_fire && (int'(cfg_chan) == i)) begin
        mode_d[i]  = mode_t'(cfg_mode);
        half_d[i]  = cfg_half_clamped;
        count_d[i] = '0;
        led_d[i]   = (cfg_mode == MODE_ON);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cfg_ready_q <= 1'b0;
      led_q       <= '0;
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i]  <= (i == 0) ? MODE_BLINK : MODE_OFF;
        half_q[i]  <= CNT_W'(DEF_HALF);
        count_q[i] <= '0;
      end
    end else begin
      cfg_ready_q <= cfg_ready_d;
      led_q       <= led_d;
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i]  <= mode_d[i];
        half_q[i]  <= half_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign led       = led_q;

endmodule
